// File: rtl/priority_arb_mux_if.sv
// priority_arb_mux_if
//   Bundles the N-channel request side and the single registered output side
//   of priority_arb_mux.
//   master : drives requests/data and out_ready (upstream + downstream logic)
//   slave  : the multiplexer itself
//   Signals:
//     in_valid  [N]        per-channel request
//     in_ready  [N]        per-channel accept, one-hot or zero
//     in_data   [N*WIDTH]  channel i at in_data[i*WIDTH +: WIDTH]
//     out_valid            output register holds a word
//     out_ready            downstream accepts this cycle
//     out_data  [WIDTH]    registered word
//     out_idx   [IDXW]     channel that supplied out_data
interface priority_arb_mux_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 6
);
    localparam int unsigned IDXW = $clog2(N);

    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [N*WIDTH-1:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [IDXW-1:0]    out_idx;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx
    );
endinterface

// File: rtl/priority_arb_mux.sv
// priority_arb_mux
//   Registered N-channel priority multiplexer with valid/ready handshakes.
//   Each cycle one requesting channel is granted and its word moved into a
//   one-entry output register, held until downstream accepts.
//   Ports:
//     clk      rising-edge clock
//     rst      synchronous reset, active-high
//     io_bus   priority_arb_mux_if.slave (request side + registered output)
//   Build option:
//     MUX_RR_EN  defined   -> round-robin arbitration (search downward from
//                             the last granted channel, wrapping)
//                undefined -> fixed priority, highest index wins
module priority_arb_mux #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 6
) (
    input  logic              clk,
    input  logic              rst,
    priority_arb_mux_if.slave io_bus
);
    localparam int unsigned IDXW = $clog2(N);

    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_data;
    logic [IDXW-1:0]    r_out_idx;

    logic               w_load_en;
    logic               w_any;
    logic [IDXW-1:0]    w_grant_idx;
    logic               w_xfer;
    logic [N-1:0]       w_in_ready;

`ifdef MUX_RR_EN
    logic [IDXW-1:0]    r_rr_ptr;
    int                 w_j;

    // Candidate order: rr_ptr-1, rr_ptr-2, ..., wrapping to N-1, rr_ptr last.
    always_comb begin
        w_any       = 1'b0;
        w_grant_idx = '0;
        w_j         = 0;
        for (int k = 1; k <= int'(N); k++) begin
            w_j = int'(r_rr_ptr) + int'(N) - k;
            if (w_j >= int'(N)) begin
                w_j = w_j - int'(N);
            end
            if (!w_any && io_bus.in_valid[IDXW'(w_j)]) begin
                w_any       = 1'b1;
                w_grant_idx = IDXW'(w_j);
            end
        end
    end
`else
    // Fixed priority: scan from the top so the highest set index wins.
    always_comb begin
        w_any       = 1'b0;
        w_grant_idx = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (!w_any && io_bus.in_valid[i]) begin
                w_any       = 1'b1;
                w_grant_idx = IDXW'(i);
            end
        end
    end
`endif

    // Output slot is free if empty or being drained this cycle.
    assign w_load_en = ~r_out_valid | io_bus.out_ready;
    assign w_xfer    = w_any & w_load_en & ~rst;

    always_comb begin
        w_in_ready = '0;
        if (w_xfer) begin
            w_in_ready[w_grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= io_bus.in_data[w_grant_idx*WIDTH +: WIDTH];
            r_out_idx   <= w_grant_idx;
        end else if (io_bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef MUX_RR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= IDXW'(N - 1);
        end else if (w_xfer) begin
            r_rr_ptr <= w_grant_idx;
        end
    end
`endif

    assign io_bus.in_ready  = w_in_ready;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.out_data  = r_out_data;
    assign io_bus.out_idx   = r_out_idx;
endmodule

// File: tb/tb_priority_arb_mux.sv
// tb_priority_arb_mux
//   Directed scenarios plus randomized traffic for priority_arb_mux (N=6,
//   WIDTH=8), checked against a transaction-level reference model and a
//   scoreboard of accepted words. Follows MUX_RR_EN like the design.
module tb_priority_arb_mux;
    localparam int unsigned W    = 8;
    localparam int unsigned N    = 6;
    localparam int unsigned IDXW = 3;
    localparam int unsigned DW   = N * W;

    logic clk;
    logic rst;

    priority_arb_mux_if #(.WIDTH(W), .N(N)) bus ();

    priority_arb_mux #(.WIDTH(W), .N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic        m_valid = 1'b0;
    logic [7:0]  m_data  = '0;
    int          m_idx   = 0;
    int          m_ptr   = N - 1;
    int          sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_grant(input logic [N-1:0] v);
`ifdef MUX_RR_EN
        for (int k = 1; k <= int'(N); k++) begin
            int c;
            c = (m_ptr - k + int'(N)) % int'(N);
            if (v[c]) return c;
        end
`else
        for (int c = int'(N) - 1; c >= 0; c--) begin
            if (v[c]) return c;
        end
`endif
        return -1;
    endfunction

    function automatic logic [DW-1:0] slot(input int ch, input logic [7:0] val);
        logic [DW-1:0] d;
        d = '0;
        d[ch*W +: W] = val;
        return d;
    endfunction

    // One clock: drive at negedge, check in_ready, advance model at posedge,
    // check registered outputs at the next negedge.
    task automatic cycle(input logic [N-1:0] v, input logic [DW-1:0] d,
                         input logic ordy, input logic r);
        int            g;
        logic [N-1:0]  exp_rdy;
        logic [N-1:0]  hs;
        logic          pre_valid;
        int            pre_word;
        int            key;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = ordy;
        rst           = r;
        #1;
        g       = ref_grant(v);
        exp_rdy = '0;
        if (!r && (!m_valid || ordy) && g >= 0) exp_rdy[g] = 1'b1;
        check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        pre_valid = bus.out_valid;
        pre_word  = int'(bus.out_idx) * 256 + int'(bus.out_data);
        hs        = bus.in_valid & bus.in_ready;
        @(posedge clk);
        if (r) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_idx   = 0;
            m_ptr   = N - 1;
            sb.delete();
        end else begin
            // Output handshake seen on the DUT: must match an accepted word.
            if (pre_valid && ordy) begin
                if (sb.size() == 0) begin
                    check("out_hs_extra", 32'(pre_valid), 32'd0);
                end else begin
                    key = sb.pop_front();
                    check("out_hs_word", 32'(pre_word), 32'(key));
                end
            end
            for (int i = 0; i < int'(N); i++) begin
                if (hs[i]) sb.push_back(i * 256 + int'(d[i*W +: W]));
            end
            if (g >= 0 && (!m_valid || ordy)) begin
                m_valid = 1'b1;
                m_data  = d[g*W +: W];
                m_idx   = g;
                m_ptr   = g;
            end else if (ordy) begin
                m_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("out_valid", 32'(bus.out_valid), 32'(m_valid));
        check("out_data", 32'(bus.out_data), 32'(m_data));
        check("out_idx", 32'(bus.out_idx), 32'(m_idx));
    endtask

    logic [DW-1:0] rnd;
    int            seq_rr [7] = '{4, 3, 2, 1, 0, 5, 4};
    int            exp_i;

    initial begin
        rst           = 1'b1;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);

        // 1: reset with all channels requesting
        cycle(6'h3F, '1, 1'b1, 1'b1);
        cycle(6'h3F, '1, 1'b1, 1'b1);
        check("t1_in_ready", 32'(bus.in_ready), 32'd0);
        check("t1_out_valid", 32'(bus.out_valid), 32'd0);

        // 2: single request on channel 0
        cycle(6'b000001, slot(0, 8'h55), 1'b1, 1'b0);
        check("t2_out_valid", 32'(bus.out_valid), 32'd1);
        check("t2_out_data", 32'(bus.out_data), 32'h55);
        check("t2_out_idx", 32'(bus.out_idx), 32'd0);

        // 3: channels 5 and 2 compete
        cycle(6'b100100, slot(5, 8'hFF) | slot(2, 8'hF0), 1'b1, 1'b0);
        check("t3_out_data", 32'(bus.out_data), 32'hFF);
        check("t3_out_idx", 32'(bus.out_idx), 32'd5);

        // 4: stall three cycles, then stream
        for (int i = 0; i < 3; i++) begin
            rnd = DW'({$urandom(), $urandom()});
            cycle(6'h3F, rnd, 1'b0, 1'b0);
            check("t4_stall_data", 32'(bus.out_data), 32'hFF);
        end
        for (int i = 0; i < 6; i++) begin
            rnd = DW'({$urandom(), $urandom()});
            cycle(6'h3F, rnd, 1'b1, 1'b0);
            check("t4_stream_valid", 32'(bus.out_valid), 32'd1);
        end

        // 5: all channels held after reset
        cycle('0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) begin
            cycle(6'h3F, '1, 1'b1, 1'b0);
`ifdef MUX_RR_EN
            exp_i = seq_rr[i];
`else
            exp_i = 5;
`endif
            check("t5_idx_seq", 32'(bus.out_idx), 32'(exp_i));
        end

        // 6: reset while stalled drops the held word
        cycle(6'b000001, slot(0, 8'hAA), 1'b1, 1'b0);
        cycle('0, '0, 1'b0, 1'b0);
        check("t6_held", 32'(bus.out_valid), 32'd1);
        cycle(6'h3F, '1, 1'b0, 1'b1);
        check("t6_rst_valid", 32'(bus.out_valid), 32'd0);
        cycle('0, '0, 1'b1, 1'b0);
        cycle('0, '0, 1'b1, 1'b0);
        check("t6_no_stale", 32'(bus.out_valid), 32'd0);

        // Random traffic
        for (int i = 0; i < 1000; i++) begin
            logic [N-1:0] v;
            v   = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom());
            rnd = DW'({$urandom(), $urandom()});
            cycle(v, rnd, $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
